// File: rtl/ref_dc_fifo_arb_pkg.sv
// Shared types for the dual-clock FIFO write-side arbiter.
//   arb_state_t   : arbiter FSM states
//   SRC_IDX_WIDTH : width of a source index (covers up to 8 sources)
//   hdr_*_lsb     : bit offsets of the fields in the optional header beat
package ref_dc_fifo_arb_pkg;

    localparam int unsigned SRC_IDX_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_DATA   = 2'd2,
        ST_SETTLE = 2'd3
    } arb_state_t;

    // Header beat: packet length in the low bits, source index just above it.
    function automatic int unsigned hdr_len_lsb();
        return 0;
    endfunction

    function automatic int unsigned hdr_src_lsb(input int unsigned len_width);
        return len_width;
    endfunction

endpackage

// File: rtl/ref_dc_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin finder.
// Finds the first requester at or above ptr_i (wrapping modulo NUM_REQ) and
// reports whether that requester is eligible; a blocked head requester is
// never skipped in favour of a later one.
//   req_i   : request vector
//   elig_i  : per-source eligibility (room in the FIFO)
//   ptr_i   : scan start index
//   valid_o : first requester found and eligible
//   idx_o   : index of the first requester in scan order
module ref_rr_pick #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = 3
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   elig_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic                 valid_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    localparam int unsigned SUM_W = IDX_WIDTH + 1;

    logic [NUM_REQ-1:0] req_rot;
    logic [NUM_REQ-1:0] elig_rot;
    logic [SUM_W-1:0]   sum;
    logic               found;

    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        req_rot  = NUM_REQ'({req_i, req_i} >> ptr_i);
        elig_rot = NUM_REQ'({elig_i, elig_i} >> ptr_i);
        valid_o  = 1'b0;
        idx_o    = '0;
        found    = 1'b0;
        sum      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                valid_o = elig_rot[k];
                sum     = SUM_W'(ptr_i) + SUM_W'(k);
                if (sum >= SUM_W'(NUM_REQ)) begin
                    sum = sum - SUM_W'(NUM_REQ);
                end
                idx_o = sum[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/ref_dc_fifo_wr_arbiter.sv
// Write-side packet scheduler for a shared dual-clock block-RAM FIFO.
// Grants whole packets round-robin, only when the FIFO has room for the
// entire packet, and drives the FIFO write port with one cycle of latency.
// Optional header beat (length + source) enabled by REF_DC_FIFO_WR_ARB_HDR_EN.
//   wr_clk, wr_rst_n : write clock, async active-low reset
//   req/req_len      : per-source packet request and length (beats)
//   req_data(_en)    : per-source beat data and valid
//   gnt              : one-hot grant held for the whole packet
//   pkt_done/pkt_src : pulse with the final FIFO write of a packet
//   fifo_wr_*        : FIFO write port; fifo_wr_level is its registered fill
module ref_dc_fifo_wr_arbiter
    import ref_dc_fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 72,
    parameter int unsigned LEN_WIDTH  = 6
) (
    input  logic                            wr_clk,
    input  logic                            wr_rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_data_en,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            pkt_done,
    output logic [SRC_IDX_WIDTH-1:0]        pkt_src,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    input  logic [ADDR_WIDTH:0]             fifo_wr_level
);

    localparam int unsigned FREE_W = ADDR_WIDTH + 2;
    localparam logic [FREE_W-1:0] DEPTH = FREE_W'(1) << ADDR_WIDTH;
`ifdef REF_DC_FIFO_WR_ARB_HDR_EN
    localparam int unsigned HDR_BEATS = 1;
`else
    localparam int unsigned HDR_BEATS = 0;
`endif

    arb_state_t               state_q;
    logic [NUM_REQ-1:0]       gnt_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [LEN_WIDTH-1:0]     beat_cnt_q;
    logic [SRC_IDX_WIDTH-1:0] idx_q;
    logic [SRC_IDX_WIDTH-1:0] rr_ptr_q;
    logic                     pkt_done_q;
    logic [SRC_IDX_WIDTH-1:0] pkt_src_q;
    logic                     fifo_wr_en_q;
    logic [DATA_WIDTH-1:0]    fifo_wr_data_q;

    logic [FREE_W-1:0]        free_c;
    logic [NUM_REQ-1:0]       elig_c;
    logic                     pick_valid_c;
    logic [SRC_IDX_WIDTH-1:0] pick_idx_c;
    logic [LEN_WIDTH-1:0]     pick_len_c;
    logic [SRC_IDX_WIDTH-1:0] rr_ptr_d;
    logic                     beat_en_c;
    logic [DATA_WIDTH-1:0]    beat_data_c;
    logic                     last_beat_c;

    // Free space is wide enough that level == depth never wraps.
    assign free_c = DEPTH - FREE_W'(fifo_wr_level);

    // A source is eligible when its whole packet (plus header) fits.
    always_comb begin
        elig_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_c[i] = (FREE_W'(req_len[i*LEN_WIDTH +: LEN_WIDTH]) + FREE_W'(HDR_BEATS)) <= free_c;
        end
    end

    ref_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (SRC_IDX_WIDTH)
    ) u_pick (
        .req_i   (req),
        .elig_i  (elig_c),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid_c),
        .idx_o   (pick_idx_c)
    );

    // Length of the picked source and the next round-robin start.
    always_comb begin
        pick_len_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_c == SRC_IDX_WIDTH'(i)) begin
                pick_len_c = req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
        if (pick_idx_c == SRC_IDX_WIDTH'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = pick_idx_c + SRC_IDX_WIDTH'(1);
        end
    end

    // Beat valid/data of the granted source only.
    always_comb begin
        beat_en_c   = 1'b0;
        beat_data_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx_q == SRC_IDX_WIDTH'(i)) begin
                beat_en_c   = req_data_en[i];
                beat_data_c = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign last_beat_c = (beat_cnt_q + LEN_WIDTH'(1)) == len_q;

`ifdef REF_DC_FIFO_WR_ARB_HDR_EN
    logic [DATA_WIDTH-1:0] hdr_c;

    always_comb begin
        hdr_c = '0;
        hdr_c[hdr_len_lsb() +: LEN_WIDTH]              = pick_len_c;
        hdr_c[hdr_src_lsb(LEN_WIDTH) +: SRC_IDX_WIDTH] = pick_idx_c;
    end
`endif

    // Arbiter FSM with registered grant, FIFO write and completion outputs.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q        <= ST_IDLE;
            gnt_q          <= '0;
            len_q          <= '0;
            beat_cnt_q     <= '0;
            idx_q          <= '0;
            rr_ptr_q       <= '0;
            pkt_done_q     <= 1'b0;
            pkt_src_q      <= '0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= '0;
        end else begin
            fifo_wr_en_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_c) begin
                        gnt_q      <= NUM_REQ'(1) << pick_idx_c;
                        len_q      <= pick_len_c;
                        idx_q      <= pick_idx_c;
                        rr_ptr_q   <= rr_ptr_d;
                        beat_cnt_q <= '0;
`ifdef REF_DC_FIFO_WR_ARB_HDR_EN
                        // Header issues during HDR, ahead of any data beat.
                        fifo_wr_en_q   <= 1'b1;
                        fifo_wr_data_q <= hdr_c;
                        state_q        <= ST_HDR;
`else
                        state_q        <= ST_DATA;
`endif
                    end
                end
                // HDR accepts beats like DATA since the grant is already visible.
                ST_HDR, ST_DATA: begin
                    state_q <= ST_DATA;
                    if (len_q == '0) begin
                        gnt_q      <= '0;
                        pkt_done_q <= 1'b1;
                        pkt_src_q  <= idx_q;
                        state_q    <= ST_SETTLE;
                    end else if (beat_en_c) begin
                        fifo_wr_en_q   <= 1'b1;
                        fifo_wr_data_q <= beat_data_c;
                        beat_cnt_q     <= beat_cnt_q + LEN_WIDTH'(1);
                        if (last_beat_c) begin
                            gnt_q      <= '0;
                            pkt_done_q <= 1'b1;
                            pkt_src_q  <= idx_q;
                            state_q    <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign pkt_done     = pkt_done_q;
    assign pkt_src      = pkt_src_q;
    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_wr_data = fifo_wr_data_q;

endmodule

// File: tb/tb_ref_dc_fifo_wr_arbiter.sv
// Directed bench for ref_dc_fifo_wr_arbiter (default build, no header beat).
module tb_ref_dc_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 72;
    localparam int unsigned LW = 6;

    logic            wr_clk = 1'b0;
    logic            wr_rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_data_en = '0;
    logic [N-1:0]    gnt;
    logic            pkt_done;
    logic [2:0]      pkt_src;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [AW:0]     fifo_wr_level = '0;

    int total = 0;
    int bad   = 0;

    ref_dc_fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .wr_clk        (wr_clk),
        .wr_rst_n      (wr_rst_n),
        .req           (req),
        .req_len       (req_len),
        .req_data      (req_data),
        .req_data_en   (req_data_en),
        .gnt           (gnt),
        .pkt_done      (pkt_done),
        .pkt_src       (pkt_src),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_level (fifo_wr_level)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_val(input int s, input int b);
        return {8'(s), 64'(b)};
    endfunction

    task automatic set_len(input int s, input int l);
        req_len[s*LW +: LW] = LW'(l);
    endtask

    task automatic set_beat(input int s, input logic en, input logic [DW-1:0] v);
        req_data[s*DW +: DW] = v;
        req_data_en[s]       = en;
    endtask

    // Grant expected on the next edge, then len back-to-back beats, then SETTLE.
    task automatic do_packet(input int s, input int len, input int base, input logic [N-1:0] drop);
        logic [N-1:0] g;
        g = N'(1) << s;
        tick();
        check("gnt_on", 96'(gnt), 96'(g));
        for (int b = 0; b < len; b++) begin
            set_beat(s, 1'b1, beat_val(s, base + b));
            tick();
            check("wr_en_beat", 96'(fifo_wr_en), 96'(1));
            check("wr_data", 96'(fifo_wr_data), 96'(beat_val(s, base + b)));
            if (b == len - 1) begin
                check("gnt_drop", 96'(gnt), 96'(0));
                check("pkt_done", 96'(pkt_done), 96'(1));
                check("pkt_src", 96'(pkt_src), 96'(s));
            end else begin
                check("gnt_hold", 96'(gnt), 96'(g));
                check("pkt_done_early", 96'(pkt_done), 96'(0));
            end
        end
        set_beat(s, 1'b0, '0);
        req = req & ~drop;
        tick();
        check("settle_wr_en", 96'(fifo_wr_en), 96'(0));
        check("settle_pkt_done", 96'(pkt_done), 96'(0));
        check("settle_gnt", 96'(gnt), 96'(0));
    endtask

    initial begin
        logic [4:0] en_pat;
        int         writes;

        // Reset values
        tick();
        tick();
        check("rst_gnt", 96'(gnt), 96'(0));
        check("rst_wr_en", 96'(fifo_wr_en), 96'(0));
        check("rst_wr_data", 96'(fifo_wr_data), 96'(0));
        check("rst_pkt_done", 96'(pkt_done), 96'(0));
        check("rst_pkt_src", 96'(pkt_src), 96'(0));
        wr_rst_n = 1'b1;

        // Single packet, source 0, len 5
        set_len(0, 5);
        req = 4'b0001;
        do_packet(0, 5, 'h100, 4'b0001);

        // All four request len 3: order 0,1,2,3,0 with 2-cycle gaps
        wr_rst_n = 1'b0;
        tick();
        wr_rst_n = 1'b1;
        for (int s = 0; s < 4; s++) set_len(s, 3);
        req = 4'b1111;
        do_packet(0, 3, 'h200, 4'b0000);
        do_packet(1, 3, 'h210, 4'b0000);
        do_packet(2, 3, 'h220, 4'b0000);
        do_packet(3, 3, 'h230, 4'b0000);
        do_packet(0, 3, 'h240, 4'b1111);

        // Space check: free 3 blocks len 4, free 4 grants
        fifo_wr_level = 8'd125;
        set_len(0, 4);
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("full_block", 96'(gnt), 96'(0));
        end
        fifo_wr_level = 8'd124;
        do_packet(0, 4, 'h300, 4'b0001);

        // Blocked head source 1 is not bypassed by fitting source 2
        fifo_wr_level = 8'd126;
        set_len(1, 3);
        set_len(2, 1);
        req = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("no_skip", 96'(gnt), 96'(0));
        end
        fifo_wr_level = 8'd125;
        do_packet(1, 3, 'h400, 4'b0010);
        do_packet(2, 1, 'h410, 4'b0100);
        fifo_wr_level = '0;

        // Gappy beats from source 3; source 0 chatters while not granted
        set_len(3, 3);
        req = 4'b1000;
        tick();
        check("gap_gnt", 96'(gnt), 96'(4'b1000));
        en_pat = 5'b11001;
        writes = 0;
        for (int c = 0; c < 5; c++) begin
            set_beat(3, en_pat[c], beat_val(3, 'h500 + c));
            set_beat(0, 1'b1, beat_val(0, 'h999));
            tick();
            check("gap_wr_en", 96'(fifo_wr_en), 96'(en_pat[c]));
            if (fifo_wr_en) begin
                writes++;
                check("gap_data", 96'(fifo_wr_data), 96'(beat_val(3, 'h500 + c)));
            end
            check("gap_gnt_state", 96'(gnt), 96'((c < 4) ? 4'b1000 : 4'b0000));
            check("gap_pkt_done", 96'(pkt_done), 96'(c == 4));
        end
        set_beat(3, 1'b0, '0);
        set_beat(0, 1'b0, '0);
        req = '0;
        tick();
        check("gap_settle_wr_en", 96'(fifo_wr_en), 96'(0));
        tick();
        check("gap_no_stray_write", 96'(fifo_wr_en), 96'(0));
        check("gap_write_count", 96'(writes), 96'(3));

        // Zero-length packet from source 2
        set_len(2, 0);
        req = 4'b0100;
        tick();
        check("len0_gnt", 96'(gnt), 96'(4'b0100));
        tick();
        req = '0;
        check("len0_gnt_drop", 96'(gnt), 96'(0));
        check("len0_pkt_done", 96'(pkt_done), 96'(1));
        check("len0_pkt_src", 96'(pkt_src), 96'(2));
        check("len0_no_write", 96'(fifo_wr_en), 96'(0));
        tick();
        check("len0_done_pulse", 96'(pkt_done), 96'(0));

        // Reset mid-packet, then arbitration restarts from pointer 0
        set_len(1, 6);
        req = 4'b0010;
        tick();
        check("abort_gnt", 96'(gnt), 96'(4'b0010));
        for (int b = 0; b < 2; b++) begin
            set_beat(1, 1'b1, beat_val(1, 'h600 + b));
            tick();
            check("abort_beat", 96'(fifo_wr_en), 96'(1));
        end
        wr_rst_n = 1'b0;
        #1;
        check("abort_gnt_clr", 96'(gnt), 96'(0));
        check("abort_wr_en_clr", 96'(fifo_wr_en), 96'(0));
        check("abort_pkt_done_clr", 96'(pkt_done), 96'(0));
        set_beat(1, 1'b0, '0);
        tick();
        wr_rst_n = 1'b1;
        set_len(1, 2);
        set_len(2, 2);
        req = 4'b0110;
        do_packet(1, 2, 'h700, 4'b0110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ref_dc_fifo_wr_arbiter.md
Name: ref_dc_fifo_wr_arbiter

Overview:
Write-side scheduler that shares one dual-clock block-RAM FIFO among NUM_REQ packet sources in the wr_clk domain.
- Grants whole packets round-robin, and only when the FIFO has room for the entire packet, so packets never interleave and a granted source never stalls on full.
- Drives the FIFO write port directly.
- Optionally prepends a header beat, so the read side can commit each packet with its advance-increment port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 7, FIFO address bits; FIFO depth = 2^ADDR_WIDTH
DATA_WIDTH, 72, FIFO data width
LEN_WIDTH, 6, packet length field width in beats; must be <= ADDR_WIDTH

Ports:
wr_clk  in  1  FIFO write-domain clock, rising edge
wr_rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-source packet request, held until gnt seen
req_len  in  NUM_REQ*LEN_WIDTH  packed packet lengths in beats; source i at [i*LEN_WIDTH +: LEN_WIDTH]; stable while req high
req_data  in  NUM_REQ*DATA_WIDTH  packed per-source beat data
req_data_en  in  NUM_REQ  per-source beat valid
gnt  out  NUM_REQ  one-hot grant, held for the whole packet
pkt_done  out  1  one-cycle pulse when a packet's last beat is issued to the FIFO
pkt_src  out  3  index of the source for pkt_done
fifo_wr_en  out  1  to FIFO wr_en
fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
fifo_wr_level  in  ADDR_WIDTH+1  from FIFO wr_level (registered, includes writes through the previous cycle)

Behaviour:
- Reset values: gnt=0, fifo_wr_en=0, fifo_wr_data=0, pkt_done=0, pkt_src=0, rr_ptr=0, state=IDLE, beat_cnt=0.
- States:
  - IDLE: pick the first requester with req high, scanning from rr_ptr upward with wrap modulo NUM_REQ. It is eligible when need <= free.
    - need = len, or len+1 with header.
    - free = 2^ADDR_WIDTH - fifo_wr_level, computed ADDR_WIDTH+2 bits wide with no truncation.
    - If the first requester in scan order is ineligible, wait; do not skip to a smaller packet (no starvation).
    - On an eligible pick: gnt[i] set next cycle; latch len and index; rr_ptr = i+1 mod NUM_REQ; go to HDR if header is enabled, else DATA.
  - DATA:
    - Each cycle with req_data_en[i] high, register req_data[i] onto fifo_wr_data and set fifo_wr_en next cycle (latency 1); beat_cnt increments.
    - Beats from non-granted sources are ignored.
    - Idle cycles (req_data_en low) are allowed.
    - On the cycle the len-th beat is accepted: gnt drops next cycle; go to SETTLE.
  - SETTLE: one cycle in which the final fifo_wr_en issues and pkt_done/pkt_src pulse. Go to IDLE. IDLE therefore sees a fifo_wr_level that includes the whole packet.
- len=0: grant for one cycle, no writes; pkt_done still pulses.
- Minimum per-packet overhead: 1 IDLE + 1 SETTLE cycle.
- A source must not deassert req while granted. gnt is cleared only at end of packet.
- fifo_wr_en never asserts when the FIFO lacks space; the read side draining only increases free space (pessimistic level is safe).
- An asynchronous reset mid-packet aborts it immediately and returns all state and outputs to reset values. A partial packet may remain in the FIFO; the system resets both FIFO domains together.

Optional Feature:
Macro REF_DC_FIFO_WR_ARB_HDR_EN.
- Defined: HDR state, one cycle, writes a header beat before the data, with need=len+1.
  - Header layout: [LEN_WIDTH-1:0]=len, [LEN_WIDTH+:3]=source index, other bits 0.
  - No pkt_done is pulsed for the header.
- Undefined: no HDR state; IDLE goes straight to DATA; need=len.

Decomposition:
- Package ref_dc_fifo_arb_pkg: state enum (IDLE, HDR, DATA, SETTLE), header field offsets, SRC_IDX_WIDTH=3.
- One sub-module, ref_rr_pick: combinational round-robin first-eligible finder. Inputs: request vector, eligible vector, pointer. Outputs: valid, index.

Test Plan:
1. Reset, with req=4'b0001, len=5, empty FIFO (level=0) -> gnt[0] 1 cycle after req. 5 fifo_wr_en beats in data order. pkt_done with pkt_src=0 one cycle after the last beat.
2. All 4 sources request len=3 simultaneously, rr_ptr=0 -> grant order 0,1,2,3,0. No beat interleaving. Gap of 2 cycles between the last beat and the next gnt.
3. FIFO depth 128 with fifo_wr_level=125, source 0 len=4 -> no gnt. Drop level to 124 -> gnt[0]. With HDR_EN defined, the grant needs level<=123.
4. Source 1 (len=3 at rr_ptr) blocked, source 2 len=1 fits -> source 2 must not be granted until source 1 is granted.
5. Granted source toggles req_data_en 1,0,0,1,1 with len=3 -> exactly 3 writes; non-granted req_data_en activity produces no writes.
6. Assert wr_rst_n low after 2 of 6 beats -> gnt and fifo_wr_en are 0 immediately; after release, the next arbitration starts from rr_ptr=0.
